// File: rtl/oled_pkg.sv
// Shared types and constant tables for the SSD1306 clock display: FSM states,
// init command list, 5x7 digit/colon font and byte-count constants.
package oled_pkg;

  typedef enum logic [2:0] {
    ST_RST_LOW,
    ST_RST_WAIT,
    ST_INIT,
    ST_CLEAR,
    ST_FRAME_CMD,
    ST_FRAME_DATA
  } state_t;

  localparam int INIT_LEN       = 25;
  localparam int CLEAR_CMD_LEN  = 6;
  localparam int CLEAR_LEN      = CLEAR_CMD_LEN + 1024;
  localparam int FRAME_CMD_LEN  = 6;
  localparam int FRAME_DATA_LEN = 64;
  localparam logic [3:0] GLYPH_COLON = 4'd10;

  localparam logic [0:INIT_LEN-1][7:0] INIT_CMDS = {
    8'hAE, 8'hD5, 8'h80, 8'hA8, 8'h3F, 8'hD3, 8'h00, 8'h40, 8'h8D,
    8'h14, 8'h20, 8'h00, 8'hA1, 8'hC8, 8'hDA, 8'h12, 8'h81, 8'hCF,
    8'hD9, 8'hF1, 8'hDB, 8'h40, 8'hA4, 8'hA6, 8'hAF
  };

  localparam logic [0:CLEAR_CMD_LEN-1][7:0] CLEAR_CMDS = {
    8'h21, 8'h00, 8'h7F, 8'h22, 8'h00, 8'h07
  };

  // Five visible columns per glyph (first column in the top byte), bit0 = top row.
  localparam logic [0:10][39:0] FONT = {
    40'h3E5149453E, 40'h00427F4000, 40'h4261514946, 40'h2141454B31,
    40'h1814127F10, 40'h2745454539, 40'h3C4A494930, 40'h0171090503,
    40'h3649494936, 40'h064949291E, 40'h0036360000
  };

  function automatic logic [7:0] font_col(input logic [3:0] glyph, input logic [2:0] col);
    logic [39:0] bits;
    bits = (glyph <= GLYPH_COLON) ? FONT[glyph] : 40'h0;
    case (col)
      3'd0:    return bits[39:32];
      3'd1:    return bits[31:24];
      3'd2:    return bits[23:16];
      3'd3:    return bits[15:8];
      3'd4:    return bits[7:0];
      default: return 8'h00;
    endcase
  endfunction

  // Returns {tens, units} as two nibbles.
  function automatic logic [7:0] bcd_split(input logic [5:0] value);
    logic [7:0] tens;
    logic [7:0] units;
    tens  = 8'(value) / 8'd10;
    units = 8'(value) - tens * 8'd10;
    return 8'((tens << 4) | units);
  endfunction

endpackage

// File: rtl/oled_spi_byte.sv
// SPI mode-0 byte shifter: 18 phases of SCK_DIV clocks per byte (16 bit phases,
// one trailing low phase with cs held, one cs-high phase); accepts the next byte in its last cycle.
module oled_spi_byte
  import oled_pkg::*;
#(
  parameter int SCK_DIV = 4
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       start,
  input  logic [7:0] byte_in,
  input  logic       dc_in,
  output logic       busy,
  output logic       done,
  output logic       sck,
  output logic       mosi,
  output logic       dc_out,
  output logic       cs
);

  localparam int CW = (SCK_DIV > 1) ? $clog2(SCK_DIV) : 1;
  localparam logic [4:0] LAST_PHASE = 5'd17;

  logic [CW-1:0] cnt_reg, cnt_next;
  logic [4:0]    phase_reg, phase_next;
  logic [7:0]    shift_reg;
  logic          busy_next, load, phase_end;

  assign load      = start && (!busy || done);
  assign phase_end = (cnt_reg == CW'(SCK_DIV - 1));

  always_comb begin
    busy_next  = busy;
    cnt_next   = cnt_reg;
    phase_next = phase_reg;
    if (load) begin
      busy_next  = 1'b1;
      cnt_next   = '0;
      phase_next = '0;
    end else if (busy) begin
      if (done) begin
        busy_next  = 1'b0;
        cnt_next   = '0;
        phase_next = '0;
      end else if (phase_end) begin
        cnt_next   = '0;
        phase_next = phase_reg + 5'd1;
      end else begin
        cnt_next = cnt_reg + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      busy      <= 1'b0;
      done      <= 1'b0;
      cnt_reg   <= '0;
      phase_reg <= '0;
      shift_reg <= '0;
      sck       <= 1'b0;
      mosi      <= 1'b0;
      dc_out    <= 1'b0;
      cs        <= 1'b1;
    end else begin
      busy      <= busy_next;
      cnt_reg   <= cnt_next;
      phase_reg <= phase_next;
      done      <= busy_next && (phase_next == LAST_PHASE) && (cnt_next == CW'(SCK_DIV - 1));
      if (load) begin
        shift_reg <= byte_in;
        mosi      <= byte_in[7];
        dc_out    <= dc_in;
        cs        <= 1'b0;
        sck       <= 1'b0;
      end else if (busy && phase_end && !done) begin
        // Odd phases below 16 are sck-high; every low phase below 16 presents the next bit.
        if (phase_next[0] && (phase_next < 5'd16)) begin
          sck <= 1'b1;
        end else begin
          sck <= 1'b0;
          if (phase_next < 5'd16) begin
            shift_reg <= {shift_reg[6:0], 1'b0};
            mosi      <= shift_reg[6];
          end else if (phase_next == LAST_PHASE) begin
            cs <= 1'b1;
          end
        end
      end
    end
  end

endmodule

// File: rtl/oled_interface.sv
// SSD1306 clock display driver: panel reset, init, optional clear (OLED_CLEAR_EN),
// then continuous redraw of "HH:MM:SS" from a per-frame snapshot of the time inputs.
module oled_interface
  import oled_pkg::*;
#(
  parameter int SCK_DIV     = 4,
  parameter int RST_CYCLES  = 1000,
  parameter int WAIT_CYCLES = 1000,
  parameter int PAGE        = 3,
  parameter int COL_START   = 32
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [4:0] hour,
  input  logic [5:0] minute,
  input  logic [5:0] second,
  output logic       sck,
  output logic       mosi,
  output logic       dc_out,
  output logic       cs,
  output logic       reset_oled
);

  state_t      state_reg, next_state;
  logic [31:0] wait_cnt_reg;
  logic [10:0] idx_reg, last_idx;
  logic [4:0]  hour_reg;
  logic [5:0]  minute_reg, second_reg;
  logic [7:0]  hour_bcd, minute_bcd, second_bcd;
  logic [7:0]  spi_byte;
  logic [3:0]  glyph;
  logic        spi_dc, spi_start, spi_busy, spi_done, accept, wait_done;

  assign hour_bcd   = bcd_split({1'b0, hour_reg});
  assign minute_bcd = bcd_split(minute_reg);
  assign second_bcd = bcd_split(second_reg);

  // The first init byte launches on the edge that ends the post-reset wait.
  assign wait_done = (state_reg == ST_RST_WAIT) && (wait_cnt_reg == 32'(WAIT_CYCLES));
  assign spi_start = wait_done || (state_reg == ST_INIT) || (state_reg == ST_CLEAR) ||
                     (state_reg == ST_FRAME_CMD) || (state_reg == ST_FRAME_DATA);
  assign accept    = spi_start && (!spi_busy || spi_done);

  always_comb begin
    spi_byte = 8'h00;
    spi_dc   = 1'b0;
    glyph    = 4'd0;
    last_idx = 11'd0;
    case (state_reg)
      ST_RST_WAIT, ST_INIT: begin
        spi_byte = INIT_CMDS[idx_reg[4:0]];
        last_idx = 11'(INIT_LEN - 1);
      end
      ST_CLEAR: begin
        if (idx_reg < 11'(CLEAR_CMD_LEN)) begin
          spi_byte = CLEAR_CMDS[idx_reg[2:0]];
        end else begin
          spi_dc = 1'b1;
        end
        last_idx = 11'(CLEAR_LEN - 1);
      end
      ST_FRAME_CMD: begin
        case (idx_reg[2:0])
          3'd0:    spi_byte = 8'h21;
          3'd1:    spi_byte = 8'(COL_START);
          3'd2:    spi_byte = 8'(COL_START + 63);
          3'd3:    spi_byte = 8'h22;
          3'd4:    spi_byte = 8'(PAGE);
          3'd5:    spi_byte = 8'(PAGE);
          default: spi_byte = 8'h00;
        endcase
        last_idx = 11'(FRAME_CMD_LEN - 1);
      end
      ST_FRAME_DATA: begin
        spi_dc = 1'b1;
        case (idx_reg[5:3])
          3'd0:    glyph = hour_bcd[7:4];
          3'd1:    glyph = hour_bcd[3:0];
          3'd3:    glyph = minute_bcd[7:4];
          3'd4:    glyph = minute_bcd[3:0];
          3'd6:    glyph = second_bcd[7:4];
          3'd7:    glyph = second_bcd[3:0];
          default: glyph = GLYPH_COLON;
        endcase
        spi_byte = font_col(glyph, idx_reg[2:0]);
        last_idx = 11'(FRAME_DATA_LEN - 1);
      end
      default: ;
    endcase
  end

  always_comb begin
    next_state = state_reg;
    case (state_reg)
      ST_RST_WAIT:   next_state = ST_INIT;
`ifdef OLED_CLEAR_EN
      ST_INIT:       next_state = ST_CLEAR;
`else
      ST_INIT:       next_state = ST_FRAME_CMD;
`endif
      ST_CLEAR:      next_state = ST_FRAME_CMD;
      ST_FRAME_CMD:  next_state = ST_FRAME_DATA;
      ST_FRAME_DATA: next_state = ST_FRAME_CMD;
      default:       next_state = state_reg;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_reg    <= ST_RST_LOW;
      wait_cnt_reg <= '0;
      idx_reg      <= '0;
      reset_oled   <= 1'b0;
      hour_reg     <= '0;
      minute_reg   <= '0;
      second_reg   <= '0;
    end else begin
      case (state_reg)
        ST_RST_LOW: begin
          if (wait_cnt_reg == 32'(RST_CYCLES)) begin
            state_reg    <= ST_RST_WAIT;
            wait_cnt_reg <= 32'd1;
            reset_oled   <= 1'b1;
          end else begin
            wait_cnt_reg <= wait_cnt_reg + 32'd1;
          end
        end
        ST_RST_WAIT: begin
          if (accept) begin
            state_reg <= ST_INIT;
            idx_reg   <= 11'd1;
          end else begin
            wait_cnt_reg <= wait_cnt_reg + 32'd1;
          end
        end
        default: begin
          if (accept) begin
            if (idx_reg == last_idx) begin
              idx_reg   <= '0;
              state_reg <= next_state;
              // Each frame is drawn from the time captured as its command phase begins.
              if (next_state == ST_FRAME_CMD) begin
                hour_reg   <= hour;
                minute_reg <= minute;
                second_reg <= second;
              end
            end else begin
              idx_reg <= idx_reg + 11'd1;
            end
          end
        end
      endcase
    end
  end

  oled_spi_byte #(.SCK_DIV(SCK_DIV)) u_spi (
    .clk    (clk),
    .reset_n(reset_n),
    .start  (spi_start),
    .byte_in(spi_byte),
    .dc_in  (spi_dc),
    .busy   (spi_busy),
    .done   (spi_done),
    .sck    (sck),
    .mosi   (mosi),
    .dc_out (dc_out),
    .cs     (cs)
  );

endmodule

// File: tb/tb_oled_interface.sv
// Directed bench for oled_interface: reset timing, byte framing, init bytes,
// frame contents, snapshot behaviour, out-of-range digits and mid-byte reset.
module tb_oled_interface;

  localparam int DIV = 2;

  localparam logic [7:0] INIT_EXP [25] = '{
    8'hAE, 8'hD5, 8'h80, 8'hA8, 8'h3F, 8'hD3, 8'h00, 8'h40, 8'h8D,
    8'h14, 8'h20, 8'h00, 8'hA1, 8'hC8, 8'hDA, 8'h12, 8'h81, 8'hCF,
    8'hD9, 8'hF1, 8'hDB, 8'h40, 8'hA4, 8'hA6, 8'hAF
  };
  localparam logic [7:0] FRAME_CMD_EXP [6] = '{8'h21, 8'h20, 8'h5F, 8'h22, 8'h03, 8'h03};
  localparam logic [39:0] FONT_EXP [11] = '{
    40'h3E5149453E, 40'h00427F4000, 40'h4261514946, 40'h2141454B31,
    40'h1814127F10, 40'h2745454539, 40'h3C4A494930, 40'h0171090503,
    40'h3649494936, 40'h064949291E, 40'h0036360000
  };

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic [4:0] hour = 5'd12;
  logic [5:0] minute = 6'd34;
  logic [5:0] second = 6'd56;
  logic       sck, mosi, dc_out, cs, reset_oled;

  int n_checks = 0;
  int n_fail = 0;
  int glyphs [8];

  always #5 clk = ~clk;

  oled_interface #(
    .SCK_DIV(DIV), .RST_CYCLES(10), .WAIT_CYCLES(10), .PAGE(3), .COL_START(32)
  ) dut (
    .clk(clk), .reset_n(reset_n), .hour(hour), .minute(minute), .second(second),
    .sck(sck), .mosi(mosi), .dc_out(dc_out), .cs(cs), .reset_oled(reset_oled)
  );

  // Byte decoder: shifts mosi on each observed sck rise, sampled on the falling clk edge.
  logic [7:0] rx_q [$];
  logic       rx_dc_q [$];
  logic [7:0] shreg = 8'h00;
  logic       byte_dc = 1'b0;
  logic       sck_prev = 1'b0, mosi_prev = 1'b0, dc_prev = 1'b0;
  int         bit_cnt = 0;
  int         dc_glitch = 0;
  int         hold_viol = 0;

  always @(negedge clk) begin
    if (!reset_n || cs) begin
      bit_cnt = 0;
    end else begin
      if (sck && !sck_prev) begin
        shreg = {shreg[6:0], mosi};
        if (bit_cnt == 0) byte_dc = dc_out;
        else if (dc_out != byte_dc) dc_glitch++;
        bit_cnt++;
        if (bit_cnt == 8) begin
          rx_q.push_back(shreg);
          rx_dc_q.push_back(byte_dc);
          bit_cnt = 0;
        end
      end
      if (sck && sck_prev && ((mosi != mosi_prev) || (dc_out != dc_prev))) hold_viol++;
    end
    sck_prev  = sck;
    mosi_prev = mosi;
    dc_prev   = dc_out;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic get_byte(input string tag, output logic [7:0] b, output logic d);
    int t = 0;
    while (rx_q.size() == 0 && t < 2000) begin
      @(posedge clk);
      t++;
    end
    n_checks++;
    assert (rx_q.size() != 0) else begin
      n_fail++;
      $error("FAIL %s: observed no byte expected byte within 2000 cycles", tag);
    end
    if (rx_q.size() != 0) begin
      b = rx_q.pop_front();
      d = rx_dc_q.pop_front();
    end else begin
      b = 8'h00;
      d = 1'b0;
    end
  endtask

  task automatic check_init(input string tag);
    logic [7:0] b;
    logic       d;
    for (int i = 0; i < 25; i++) begin
      get_byte($sformatf("%s_wait%0d", tag, i), b, d);
      check($sformatf("%s_byte%0d", tag, i), 32'(b), 32'(INIT_EXP[i]));
      check($sformatf("%s_dc%0d", tag, i), 32'(d), 32'd0);
    end
    $display("%s: 25 init bytes received", tag);
  endtask

  // Checks one frame against glyphs[]; optionally changes the time after data byte change_at.
  task automatic check_frame(input string tag, input int change_at);
    logic [7:0]  b, exp;
    logic        d;
    logic [39:0] row;
    int          c;
    for (int i = 0; i < 6; i++) begin
      get_byte($sformatf("%s_cwait%0d", tag, i), b, d);
      check($sformatf("%s_cmd%0d", tag, i), 32'(b), 32'(FRAME_CMD_EXP[i]));
      check($sformatf("%s_cdc%0d", tag, i), 32'(d), 32'd0);
    end
    for (int i = 0; i < 64; i++) begin
      get_byte($sformatf("%s_dwait%0d", tag, i), b, d);
      row = FONT_EXP[glyphs[i / 8]];
      c   = i % 8;
      exp = (c < 5) ? row[39 - 8 * c -: 8] : 8'h00;
      check($sformatf("%s_data%0d", tag, i), 32'(b), 32'(exp));
      check($sformatf("%s_ddc%0d", tag, i), 32'(d), 32'd1);
      if (i == change_at) begin
        second = 6'd57;
        hour   = 5'd31;
      end
    end
    $display("%s: 6 cmd + 64 data bytes received", tag);
  endtask

  initial begin
    int n, hi;
    logic [7:0] b;
    logic d;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_cs", 32'(cs), 32'd1);
    check("rst_sck", 32'(sck), 32'd0);
    check("rst_mosi", 32'(mosi), 32'd0);
    check("rst_dc", 32'(dc_out), 32'd0);
    check("rst_reset_oled", 32'(reset_oled), 32'd0);
    $display("reset: outputs checked");

    // Panel reset pulse and wait before the first byte
    @(negedge clk);
    reset_n = 1'b1;
    n = 0;
    while (n < 100) begin
      @(posedge clk);
      #1;
      if (reset_oled) break;
      n++;
    end
    check("reset_oled_low_cycles", 32'(n), 32'd10);
    n = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
    end while (cs && n < 100);
    check("first_cs_fall_delay", 32'(n), 32'd10);
    $display("release: reset_oled low and wait intervals measured");

    // Byte period and cs-high interval
    n = 0;
    hi = 0;
    while (cs == 1'b0 && n < 200) begin @(posedge clk); #1; n++; end
    while (cs == 1'b1 && n < 200) begin @(posedge clk); #1; n++; hi++; end
    check("byte_period", 32'(n), 32'(18 * DIV));
    check("cs_high_cycles", 32'(hi), 32'(DIV));
    $display("framing: byte period %0d cs-high %0d", n, hi);

    check_init("init");

`ifdef OLED_CLEAR_EN
    n = 0;
    for (int i = 0; i < 6; i++) begin
      get_byte("clr_cwait", b, d);
      if (d != 1'b0) n++;
    end
    hi = 0;
    for (int i = 0; i < 1024; i++) begin
      get_byte("clr_dwait", b, d);
      if (b != 8'h00 || d != 1'b1) hi++;
    end
    check("clear_cmd_dc_errors", 32'(n), 32'd0);
    check("clear_data_errors", 32'(hi), 32'd0);
    $display("clear: 1030 bytes received");
`endif

    glyphs = '{1, 2, 10, 3, 4, 10, 5, 6};
    check_frame("frame1", -1);
    check_frame("frame2", 20);
    glyphs = '{3, 1, 10, 3, 4, 10, 5, 7};
    check_frame("frame3", -1);

    // Reset pulse in the middle of a byte
    n = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
    end while (!(sck == 1'b1 && cs == 1'b0) && n < 200);
    @(negedge clk);
    reset_n = 1'b0;
    @(posedge clk);
    #1;
    check("midbyte_cs", 32'(cs), 32'd1);
    check("midbyte_sck", 32'(sck), 32'd0);
    check("midbyte_reset_oled", 32'(reset_oled), 32'd0);
    rx_q.delete();
    rx_dc_q.delete();
    @(negedge clk);
    reset_n = 1'b1;
    $display("midbyte reset: outputs checked");
    check_init("reinit");

    check("dc_stable_within_byte", 32'(dc_glitch), 32'd0);
    check("mosi_dc_stable_sck_high", 32'(hold_viol), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: observed no end of test expected finish before 3 ms");
    $fatal(1, "watchdog expired");
  end

endmodule
